// File: rtl/ir_cmd_pkg.sv
// rtl/ir_cmd_pkg.sv - command codes, reset defaults and motion state type for the IR classifier
package ir_cmd_pkg;

    localparam int unsigned CMD_MODE_REMOTE = 69;
    localparam int unsigned CMD_MODE_TRACK  = 70;
    localparam int unsigned CMD_MODE_FOLLOW = 71;
    localparam int unsigned CMD_MODE_AVOID  = 68;
    localparam int unsigned CMD_PWM_LOW     = 22;
    localparam int unsigned CMD_PWM_MID     = 25;
    localparam int unsigned CMD_PWM_HIGH    = 13;
    localparam int unsigned CMD_MOVE_FWD    = 24;
    localparam int unsigned CMD_MOVE_LEFT   = 8;
    localparam int unsigned CMD_MOVE_RIGHT  = 90;
    localparam int unsigned CMD_MOVE_BACK   = 82;
    localparam int unsigned CMD_MOVE_STOP   = 28;

    localparam int unsigned RST_MODE = CMD_MODE_REMOTE;
    localparam int unsigned RST_PWM  = CMD_PWM_MID;
    localparam int unsigned RST_MOVE = CMD_MOVE_STOP;

    typedef enum logic {
        STOPPED = 1'b0,
        MOVING  = 1'b1
    } motion_state_e;

    function automatic logic is_mode_code(input int unsigned c);
        return (c == CMD_MODE_REMOTE) || (c == CMD_MODE_TRACK) ||
               (c == CMD_MODE_FOLLOW) || (c == CMD_MODE_AVOID);
    endfunction

    function automatic logic is_pwm_code(input int unsigned c);
        return (c == CMD_PWM_LOW) || (c == CMD_PWM_MID) || (c == CMD_PWM_HIGH);
    endfunction

    function automatic logic is_move_code(input int unsigned c);
        return (c == CMD_MOVE_FWD) || (c == CMD_MOVE_LEFT) || (c == CMD_MOVE_RIGHT) ||
               (c == CMD_MOVE_BACK) || (c == CMD_MOVE_STOP);
    endfunction

endpackage

// File: rtl/ir_cmd_classifier_if.sv
// rtl/ir_cmd_classifier_if.sv - decoder-side strobe inputs and held control outputs of the classifier
interface ir_cmd_classifier_if #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
);
    logic              data_valid;
    logic [DATA_W-1:0] data;
    logic              data_repeat;
    logic [DATA_W-1:0] data_mode;
    logic [DATA_W-1:0] data_pwm;
    logic [DATA_W-1:0] data_move;
    logic              mode_upd;
    logic              pwm_upd;
    logic              move_upd;
    logic              moving;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output data_valid, data, data_repeat,
        input  data_mode, data_pwm, data_move, mode_upd, pwm_upd, move_upd, moving, err_cnt
    );

    modport slave (
        input  data_valid, data, data_repeat,
        output data_mode, data_pwm, data_move, mode_upd, pwm_upd, move_upd, moving, err_cnt
    );
endinterface

// File: rtl/ir_hold_timer.sv
// rtl/ir_hold_timer.sv - loadable down-counter that parks at zero and flags expiry
module ir_hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clear,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] cnt;

    // clear outranks load so a stop issued alongside a reload always wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/ir_cmd_classifier.sv
// rtl/ir_cmd_classifier.sv - routes IR command codes to mode/speed/motion registers with motion auto-stop
module ir_cmd_classifier
    import ir_cmd_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 5_000_000,
    parameter int ERR_W    = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    ir_cmd_classifier_if.slave    bus
);
    localparam int TMR_W = $clog2(HOLD_CYC);
    localparam logic [DATA_W-1:0] STOP_CODE = DATA_W'(CMD_MOVE_STOP);

    motion_state_e     state, state_nxt;
    logic [DATA_W-1:0] mode_q, mode_nxt;
    logic [DATA_W-1:0] pwm_q, pwm_nxt;
    logic [DATA_W-1:0] move_q, move_nxt;
    logic [ERR_W-1:0]  err_q, err_nxt;
    logic              mode_upd_q, pwm_upd_q, move_upd_q;
    logic              tmr_load, tmr_clear, tmr_expired;
    int unsigned       code;

    assign code = 32'(bus.data);

    ir_hold_timer #(.W(TMR_W)) u_hold_timer (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .load     (tmr_load),
        .load_val (TMR_W'(HOLD_CYC - 1)),
        .clear    (tmr_clear),
        .en       (state == MOVING),
        .expired  (tmr_expired)
    );

    // any strobe this cycle, even one that changes nothing, defers expiry
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        pwm_nxt   = pwm_q;
        move_nxt  = move_q;
        err_nxt   = err_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        if (bus.data_valid) begin
            if (bus.data_repeat) begin
                if (state == MOVING) begin
                    tmr_load = 1'b1;
                end
            end else if (is_mode_code(code)) begin
                if (bus.data != mode_q) begin
                    mode_nxt  = bus.data;
                    move_nxt  = STOP_CODE;
                    state_nxt = STOPPED;
                    tmr_clear = 1'b1;
                end
            end else if (is_pwm_code(code)) begin
                pwm_nxt = bus.data;
            end else if (is_move_code(code)) begin
                move_nxt = bus.data;
                if (code == CMD_MOVE_STOP) begin
                    state_nxt = STOPPED;
                    tmr_clear = 1'b1;
                end else begin
                    state_nxt = MOVING;
                    tmr_load  = 1'b1;
                end
            end else if (err_q != '1) begin
                err_nxt = err_q + 1'b1;
            end
        end else if ((state == MOVING) && tmr_expired) begin
            move_nxt  = STOP_CODE;
            state_nxt = STOPPED;
            tmr_clear = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= STOPPED;
            mode_q     <= DATA_W'(RST_MODE);
            pwm_q      <= DATA_W'(RST_PWM);
            move_q     <= DATA_W'(RST_MOVE);
            err_q      <= '0;
            mode_upd_q <= 1'b0;
            pwm_upd_q  <= 1'b0;
            move_upd_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode_q     <= mode_nxt;
            pwm_q      <= pwm_nxt;
            move_q     <= move_nxt;
            err_q      <= err_nxt;
            mode_upd_q <= (mode_nxt != mode_q);
            pwm_upd_q  <= (pwm_nxt != pwm_q);
            move_upd_q <= (move_nxt != move_q);
        end
    end

    assign bus.data_mode = mode_q;
    assign bus.data_pwm  = pwm_q;
    assign bus.data_move = move_q;
    assign bus.mode_upd  = mode_upd_q;
    assign bus.pwm_upd   = pwm_upd_q;
    assign bus.move_upd  = move_upd_q;
    assign bus.moving    = (state == MOVING);
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_ir_cmd_classifier.sv
// tb/tb_ir_cmd_classifier.sv - directed and random checks of ir_cmd_classifier against a deadline-based model
module tb_ir_cmd_classifier;
    localparam int DW = 8;
    localparam int EW = 8;
    localparam int H  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ir_cmd_classifier_if #(.DATA_W(DW), .ERR_W(EW)) bus ();

    ir_cmd_classifier #(.DATA_W(DW), .HOLD_CYC(H), .ERR_W(EW)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int m_mode, m_pwm, m_move, m_err;
    bit m_moving, m_mu, m_pu, m_vu;
    int last_ref, edge_no;

    int pool[12] = '{69, 70, 71, 68, 22, 25, 13, 24, 8, 90, 82, 28};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 69; m_pwm = 25; m_move = 28; m_err = 0;
        m_moving = 0; m_mu = 0; m_pu = 0; m_vu = 0;
        last_ref = 0; edge_no = 0;
    endfunction

    // motion lapses once HOLD_CYC edges have passed since the last refresh and no strobe arrives
    function automatic void model_edge(input bit v, input bit r, input int d);
        int pm, pp, pv;
        pm = m_mode; pp = m_pwm; pv = m_move;
        edge_no++;
        if (v) begin
            if (r) begin
                if (m_moving) last_ref = edge_no;
            end else if (d inside {69, 70, 71, 68}) begin
                if (d != m_mode) begin
                    m_mode = d; m_move = 28; m_moving = 0;
                end
            end else if (d inside {22, 25, 13}) begin
                m_pwm = d;
            end else if (d inside {24, 8, 90, 82}) begin
                m_move = d; m_moving = 1; last_ref = edge_no;
            end else if (d == 28) begin
                m_move = 28; m_moving = 0;
            end else if (m_err < 255) begin
                m_err++;
            end
        end else if (m_moving && (edge_no - last_ref >= H)) begin
            m_move = 28; m_moving = 0;
        end
        m_mu = (pm != m_mode);
        m_pu = (pp != m_pwm);
        m_vu = (pv != m_move);
    endfunction

    task automatic check_all();
        chk("data_mode", bus.data_mode, m_mode);
        chk("data_pwm",  bus.data_pwm,  m_pwm);
        chk("data_move", bus.data_move, m_move);
        chk("mode_upd",  bus.mode_upd,  m_mu);
        chk("pwm_upd",   bus.pwm_upd,   m_pu);
        chk("move_upd",  bus.move_upd,  m_vu);
        chk("moving",    bus.moving,    m_moving);
        chk("err_cnt",   bus.err_cnt,   m_err);
    endtask

    task automatic cycle(input bit v, input bit r, input logic [7:0] d);
        bus.data_valid  = v;
        bus.data_repeat = r;
        bus.data        = d;
        @(posedge clk);
        model_edge(v, r, int'(d));
        #1;
        bus.data_valid  = 1'b0;
        bus.data_repeat = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'd0);
    endtask

    initial begin
        bus.data_valid  = 1'b0;
        bus.data_repeat = 1'b0;
        bus.data        = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all();
        chk("rst_mode", bus.data_mode, 69);
        chk("rst_pwm",  bus.data_pwm,  25);
        chk("rst_move", bus.data_move, 28);

        // forward, no refresh: lapses exactly HOLD_CYC edges later
        cycle(1, 0, 8'd24);
        chk("fwd_move", bus.data_move, 24);
        chk("fwd_upd",  bus.move_upd,  1);
        chk("fwd_moving", bus.moving,  1);
        idle(H - 1);
        chk("fwd_hold", bus.data_move, 24);
        idle(1);
        chk("fwd_lapse", bus.data_move, 28);
        chk("fwd_lapse_upd", bus.move_upd, 1);

        // repeat frames at the latest allowed refresh point
        cycle(1, 0, 8'd24);
        for (int p = 0; p < 5; p++) begin
            idle(H - 2);
            cycle(1, 1, 8'd0);
            chk("rep_hold", bus.data_move, 24);
        end
        idle(H - 1);
        chk("rep_last_hold", bus.data_move, 24);
        idle(1);
        chk("rep_lapse", bus.data_move, 28);

        // mode change while moving forces a stop
        cycle(1, 0, 8'd90);
        cycle(1, 0, 8'd70);
        chk("modechg_mode", bus.data_mode, 70);
        chk("modechg_move", bus.data_move, 28);
        chk("modechg_mu", bus.mode_upd, 1);
        chk("modechg_vu", bus.move_upd, 1);
        cycle(1, 0, 8'd70);
        chk("modesame_mu", bus.mode_upd, 0);
        chk("modesame_vu", bus.move_upd, 0);

        // speed presets leave motion alone
        cycle(1, 0, 8'd24);
        cycle(1, 0, 8'd25);
        chk("pwm_same_pu", bus.pwm_upd, 0);
        cycle(1, 0, 8'd25);
        cycle(1, 0, 8'd13);
        chk("pwm_13", bus.data_pwm, 13);
        chk("pwm_13_pu", bus.pwm_upd, 1);
        chk("pwm_moving", bus.moving, 1);
        idle(H + 1);

        for (int k = 0; k < 600; k++) begin
            bit v, r;
            logic [7:0] d;
            v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 4) == 0);
            d = ($urandom_range(0, 9) < 7) ? 8'(pool[$urandom_range(0, 11)]) : 8'($urandom_range(0, 255));
            cycle(v, r, d);
            if ($urandom_range(0, 15) == 0) idle($urandom_range(H - 2, H + 1));
        end

        for (int k = 0; k < 300; k++) cycle(1, 0, 8'd200);
        chk("err_sat", bus.err_cnt, 255);

        // asynchronous reset mid-motion, checked before the next rising edge
        cycle(1, 0, 8'd82);
        cycle(1, 0, 8'd22);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_mode", bus.data_mode, 69);
        chk("arst_pwm",  bus.data_pwm,  25);
        chk("arst_move", bus.data_move, 28);
        chk("arst_moving", bus.moving, 0);
        chk("arst_err", bus.err_cnt, 0);
        chk("arst_pulses", {bus.mode_upd, bus.pwm_upd, bus.move_upd}, 0);
        @(negedge clk);
        rst = 1'b0;
        check_all();
        cycle(1, 0, 8'd8);
        chk("post_rst_move", bus.data_move, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ir_cmd_classifier.md
# ir_cmd_classifier

Registered classifier for decoded IR remote command codes. It sits between the IR NEC decoder and the motor/mode control logic. Each valid command byte is routed to one of three held control registers: work mode, speed (PWM) preset, or motion. Compared with a plain code sorter it adds a valid/repeat handshake, change-pulse outputs, an automatic motion stop when key repeats cease, a mode-change safety stop, and an unknown-code counter.

## Interface
- DATA_W, 8: command code width; codes compare zero-extended.
- HOLD_CYC, 5_000_000: cycles a motion command stays active without refresh (100 ms at 50 MHz); must be ≥ 2.
- ERR_W, 8: width of the unknown-code counter.

- sys_clk  in  1  system clock.
- sys_rst  in  1  reset; asynchronous, active-high.
- data_valid  in  1  one-cycle strobe: data/data_repeat are valid.
- data  in  DATA_W  decoded command code.
- data_repeat  in  1  with data_valid: NEC repeat frame; data is ignored.
- data_mode  out  DATA_W  current work mode code.
- data_pwm  out  DATA_W  current speed preset code.
- data_move  out  DATA_W  current motion code.
- mode_upd, pwm_upd, move_upd  out  1 each  one-cycle pulse when the matching register value changes.
- moving  out  1  high while a non-stop motion code is held.
- err_cnt  out  ERR_W  saturating count of unrecognised codes.

## Operation
- Code sets:
  - Mode: 69 remote, 70 line-track, 71 follow, 68 ultrasonic avoid.
  - PWM: 22, 25, 13.
  - Move: 24 fwd, 8 left, 90 right, 82 back, 28 stop.
- Reset values:
  - data_mode = 69, data_pwm = 25, data_move = 28.
  - All pulses = 0, moving = 0, err_cnt = 0, timer = 0.
  - Motion FSM = STOPPED.
- Mode code: load data_mode.
  - If the value differs from the current mode, also force data_move = 28 and enter STOPPED.
  - If the value is the same, nothing changes.
- PWM code: load data_pwm. This never affects motion.
- Move code, non-stop: load data_move, load the timer with HOLD_CYC-1, enter MOVING.
- Move code 28: load data_move = 28, enter STOPPED, clear the timer.
- Repeat frame (data_valid & data_repeat):
  - In MOVING: reload the timer with HOLD_CYC-1. data_move is unchanged.
  - In STOPPED: ignored.
- Unknown code (valid, not a repeat, in no set): err_cnt increments and saturates at all-ones. No register changes.
- Motion FSM:
  - STOPPED → MOVING on a non-stop move code.
  - MOVING → STOPPED on code 28, on a mode change, or on timer expiry.
  - MOVING → MOVING on a repeat frame or a new move code (timer reloads).
  - On expiry (timer == 0 in MOVING with no valid input that cycle): data_move = 28.
- moving = (state == MOVING).
- *_upd pulses iff the register value changes. Re-receiving an identical code gives no pulse, but a move code still reloads the timer.
- Priority in a single cycle: a valid input beats timer expiry. A mode change beats everything, which matters only for the stop it forces.
- sys_rst asserted mid-motion returns everything to reset values immediately, asynchronously.

## Timing
- All outputs are registered. Latency from data_valid to updated register plus pulse is 1 cycle.
- A back-to-back data_valid on every cycle is accepted; each strobe is processed independently.
- Timeout: the last refresh is at cycle t (valid at edge t). data_move returns to 28 and move_upd pulses at edge t+HOLD_CYC. A refresh at edge t+HOLD_CYC-1 or earlier prevents this.
- The timer is $clog2(HOLD_CYC) bits wide and decrements only in MOVING.

## Structure
- Shared package ir_cmd_pkg holds:
  - localparams for all twelve codes (CMD_MODE_REMOTE … CMD_MOVE_STOP);
  - the reset defaults;
  - the motion state enum {STOPPED, MOVING}.
- One sub-module: ir_hold_timer. It is a loadable down-counter with a load/clear/enable interface and an expiry flag, and it is reused later for ultrasonic echo timeouts.
- Classification decode is combinational in the top; all state is in the top plus the timer.

## Test plan
- Reset release: data_mode=69, data_pwm=25, data_move=28, moving=0, err_cnt=0, no pulses.
- Send 24: 1 cycle later data_move=24, move_upd pulse, moving=1. With no repeats, after HOLD_CYC cycles data_move=28 and move_upd pulses again.
- Send 24, then repeat frames every HOLD_CYC-1 cycles for 5 periods: data_move holds 24 throughout. Stop repeats: reverts exactly HOLD_CYC cycles after the last repeat.
- While moving at 90, send 70: data_mode=70, data_move=28, mode_upd and move_upd in the same cycle. Then send 70 again: no pulses.
- Send 25 twice, then 13: first 25 gives no pulse (already 25); 13 gives data_pwm=13 with pwm_upd. Motion unaffected.
- Send 300 unknown codes with ERR_W=8: err_cnt saturates at 255. Also: assert sys_rst mid-MOVING and check that outputs return to reset values before the next edge.
